stream_mux_rr: RTL and testbench

// - Parametrised N-channel, W-bit stream multiplexer with val/rdy handshake and registered output.
// - Successor to the combinational 2:1 gate-level muxes: arbitrates among NCH requesters.
// - Holds the selected message in an output register until downstream accepts it.
// - Used wherever several producers share one consumer port, e.g. memory request or writeback merge.
//

---
 rtl/stream_mux_pkg.sv | 28 ++
 rtl/stream_mux_rr_arb.sv | 66 ++++++
 rtl/stream_mux_rr.sv | 67 ++++++
 tb/tb_stream_mux_rr.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared widths and helpers for the stream_mux family of multiplexers.
package stream_mux_pkg;

  // Widest channel vector the one-hot helper accepts.
  localparam int unsigned MAX_CH = 64;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // OR-reduction encoder; callers truncate the result to their own IDXW.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Grant logic for stream_mux_rr. STREAM_MUX_RR_ARB_EN selects round-robin with a
// priority pointer; without it the block is a plain lowest-index priority encoder.
module stream_mux_rr_arb
  import stream_mux_pkg::*;
#(
  parameter  int unsigned NCH  = 4,
  localparam int unsigned IDXW = clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] grant
);

`ifdef STREAM_MUX_RR_ARB_EN
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gidx;

  // Cyclic search starting at ptr; the wrap handles non-power-of-two NCH.
  always_comb begin : rr_search
    logic            found;
    logic [IDXW-1:0] c;
    grant = '0;
    found = 1'b0;
    c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(ptr) + k >= NCH) c = IDXW'(32'(ptr) + k - NCH);
      else                     c = IDXW'(32'(ptr) + k);
      if (!found && req[c]) begin
        grant[c] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign gidx = IDXW'(onehot_to_idx(MAX_CH'(grant)));

  // Pointer moves just past the channel that was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (32'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
    end
  end
`else
  logic unused_arb;

  always_comb begin : fixed_search
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Fixed priority is stateless; the sequencing inputs are intentionally unused.
  assign unused_arb = ^{clk, rst_n, adv};
`endif

endmodule

// File: rtl/stream_mux_rr.sv
// NCH-to-1 val/rdy stream multiplexer with a registered output stage.
// Arbitration is round-robin when STREAM_MUX_RR_ARB_EN is defined, fixed priority otherwise.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned NCH  = 4,
  parameter  int unsigned W    = 4,
  localparam int unsigned IDXW = clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_val,
  output logic [NCH-1:0]   in_rdy,
  input  logic [NCH*W-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [W-1:0]     out_msg,
  output logic [IDXW-1:0]  out_chan
);

  logic [NCH-1:0]  grant;
  logic            space;
  logic            in_xfer;
  logic [W-1:0]    sel_msg;
  logic [IDXW-1:0] sel_chan;

  stream_mux_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (in_val),
    .adv   (in_xfer),
    .grant (grant)
  );

  // Register can accept when empty or being drained this cycle.
  assign space   = ~out_val | out_rdy;
  assign in_rdy  = grant & {NCH{space & rst_n}};
  assign in_xfer = |(in_val & in_rdy);

  // AND-OR select; grant is one-hot or zero.
  always_comb begin
    sel_msg = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sel_msg = sel_msg | (in_msg[i*W +: W] & {W{grant[i]}});
    end
  end

  assign sel_chan = IDXW'(onehot_to_idx(MAX_CH'(grant)));

  // Output register: reload on input transfer, else clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_msg  <= '0;
      out_chan <= '0;
    end else if (in_xfer) begin
      out_val  <= 1'b1;
      out_msg  <= sel_msg;
      out_chan <= sel_chan;
    end else if (out_rdy) begin
      out_val  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (NCH=4, W=4); follows STREAM_MUX_RR_ARB_EN.
module tb_stream_mux_rr;
  localparam int unsigned NCH  = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned IDXW = 2;

`ifdef STREAM_MUX_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   in_val;
  logic [NCH-1:0]   in_rdy;
  logic [NCH*W-1:0] in_msg;
  logic             out_val;
  logic             out_rdy;
  logic [W-1:0]     out_msg;
  logic [IDXW-1:0]  out_chan;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: contents of the output register and the priority pointer.
  bit          m_val;
  logic [W-1:0] m_msg;
  int          m_chan;
  int          m_ptr;

  logic [W-1:0] sb_msg[$];
  int           sb_chan[$];

  stream_mux_rr #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(input logic [NCH-1:0] v);
    int start;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < NCH; k++) begin
      if (v[(start + k) % NCH]) return (start + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] model_rdy();
    int g;
    g = model_grant(in_val);
    if (g >= 0 && (!m_val || out_rdy === 1'b1) && rst_n === 1'b1) return NCH'(1) << g;
    return '0;
  endfunction

  task automatic model_reset();
    m_val = 1'b0; m_msg = '0; m_chan = 0; m_ptr = 0;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [NCH*W-1:0] m, input logic r);
    in_val = v; in_msg = m; out_rdy = r;
    #1;
  endtask

  // Advance the model by the rules of one clock edge, then step past the edge.
  task automatic tick();
    int g;
    g = model_grant(in_val);
    if (rst_n === 1'b1) begin
      if ((!m_val || out_rdy === 1'b1) && g >= 0) begin
        m_val = 1'b1; m_msg = in_msg[g*W +: W]; m_chan = g; m_ptr = (g + 1) % NCH;
      end else if (m_val && out_rdy === 1'b1) begin
        m_val = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_val = '0; out_rdy = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    logic [NCH*W-1:0] m;
    m = (NCH*W)'($urandom);
    model_reset();
    rst_n = 1'b0;
    drive(4'b1111, m, 1'b1);
    @(posedge clk); #1; @(posedge clk); #1;
    n_tests++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b want 0", out_val); end
    n_tests++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_in_rdy got %b want 0000", in_rdy); end
    n_tests++; if (out_msg !== 4'h0 || out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_out_msg got %h/%0d want 0/0", out_msg, out_chan); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_rdy !== 4'b0001) begin n_fail++; $display("FAIL release_in_rdy got %b want 0001", in_rdy); end
    tick();
    n_tests++; if (out_val !== 1'b1 || out_msg !== m[3:0] || out_chan !== 2'd0) begin
      n_fail++; $display("FAIL release_load got %b/%h/%0d want 1/%h/0", out_val, out_msg, out_chan, m[3:0]);
    end
  endtask

  task automatic test_single();
    logic [NCH*W-1:0] m;
    logic [W-1:0]     nib;
    reset_dut();
    drive(4'b0100, 16'h0A00, 1'b1);
    n_tests++; if (in_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_rdy got %b want 0100", in_rdy); end
    tick();
    n_tests++; if (out_val !== 1'b1 || out_msg !== 4'hA || out_chan !== 2'd2) begin
      n_fail++; $display("FAIL single_load got %b/%h/%0d want 1/a/2", out_val, out_msg, out_chan);
    end
    for (int k = 0; k < 4; k++) begin
      nib = W'($urandom);
      m = '0; m[11:8] = nib;
      drive(4'b0100, m, 1'b1);
      n_tests++; if (in_rdy !== 4'b0100) begin n_fail++; $display("FAIL b2b_rdy[%0d] got %b want 0100", k, in_rdy); end
      tick();
      n_tests++; if (out_val !== 1'b1 || out_msg !== nib || out_chan !== 2'd2) begin
        n_fail++; $display("FAIL b2b_load[%0d] got %b/%h/%0d want 1/%h/2", k, out_val, out_msg, out_chan, nib);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_m;
    int           exp_c;
    reset_dut();
    drive(4'b0010, 16'h0050, 1'b1);
    tick();
    n_tests++; if (out_msg !== 4'h5 || out_chan !== 2'd1) begin n_fail++; $display("FAIL bp_load got %h/%0d want 5/1", out_msg, out_chan); end
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 16'h9876, 1'b0);
      n_tests++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_rdy[%0d] got %b want 0000", k, in_rdy); end
      tick();
      n_tests++; if (out_val !== 1'b1 || out_msg !== 4'h5 || out_chan !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b/%h/%0d want 1/5/1", k, out_val, out_msg, out_chan);
      end
    end
    drive(4'b1111, 16'h9876, 1'b1);
    n_tests++; if (in_rdy !== model_rdy() || in_rdy === 4'b0000) begin
      n_fail++; $display("FAIL bp_release_rdy got %b want %b", in_rdy, model_rdy());
    end
    exp_c = RR ? 2 : 0;
    exp_m = RR ? 4'h8 : 4'h6;
    tick();
    n_tests++; if (out_val !== 1'b1 || out_msg !== exp_m || out_chan !== IDXW'(exp_c)) begin
      n_fail++; $display("FAIL bp_release_load got %b/%h/%0d want 1/%h/%0d", out_val, out_msg, out_chan, exp_m, exp_c);
    end
  endtask

  task automatic test_round_robin();
    int exp_c;
    reset_dut();
    drive(4'b1111, 16'h4321, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_c = RR ? k % NCH : 0;
      n_tests++; if (out_val !== 1'b1 || out_chan !== IDXW'(exp_c) || out_msg !== W'(exp_c + 1)) begin
        n_fail++; $display("FAIL rr_seq[%0d] got %b/%0d/%h want 1/%0d/%h", k, out_val, out_chan, out_msg, exp_c, exp_c + 1);
      end
    end
  endtask

  task automatic test_wrap_skip();
    int exp_c;
    reset_dut();
    drive(4'b0100, 16'h0700, 1'b1);
    tick();
    n_tests++; if (out_chan !== 2'd2) begin n_fail++; $display("FAIL wrap_pre got %0d want 2", out_chan); end
    drive(4'b0011, 16'h00BC, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_c = (RR && k == 1) ? 1 : 0;
      n_tests++; if (out_chan !== IDXW'(exp_c) || out_msg !== (exp_c == 1 ? 4'hB : 4'hC)) begin
        n_fail++; $display("FAIL wrap_seq[%0d] got %0d/%h want %0d", k, out_chan, out_msg, exp_c);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    drive(4'b0100, 16'h0300, 1'b1);
    tick();
    drive(4'b1111, 16'h9876, 1'b0);
    tick();
    n_tests++; if (out_val !== 1'b1 || out_msg !== 4'h3) begin n_fail++; $display("FAIL ar_stall got %b/%h want 1/3", out_val, out_msg); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_val !== 1'b0 || out_msg !== 4'h0 || out_chan !== 2'd0 || in_rdy !== 4'b0000) begin
      n_fail++; $display("FAIL ar_clear got %b/%h/%0d/%b want 0/0/0/0000", out_val, out_msg, out_chan, in_rdy);
    end
    rst_n = 1'b1;
    model_reset();
    #1;
    n_tests++; if (in_rdy !== 4'b0001) begin n_fail++; $display("FAIL ar_ptr_rdy got %b want 0001", in_rdy); end
    tick();
    n_tests++; if (out_val !== 1'b1 || out_chan !== 2'd0 || out_msg !== 4'h6) begin
      n_fail++; $display("FAIL ar_reload got %b/%0d/%h want 1/0/6", out_val, out_chan, out_msg);
    end
  endtask

  // Random producers that obey the hold-until-ready rule, checked by model and scoreboard.
  task automatic test_random(input int cycles);
    bit               pv[NCH];
    logic [W-1:0]     pm[NCH];
    logic [NCH-1:0]   v;
    logic [NCH*W-1:0] m;
    logic [NCH-1:0]   exp_rdy;
    logic             r;
    int               acc;
    bit               busy;
    logic [W-1:0]     em;
    int               ec;
    reset_dut();
    sb_msg.delete(); sb_chan.delete();
    for (int i = 0; i < NCH; i++) begin pv[i] = 1'b0; pm[i] = '0; end
    for (int t = 0; t < cycles + 40; t++) begin
      busy = 1'b0;
      for (int i = 0; i < NCH; i++) busy = busy | pv[i];
      if (t >= cycles && !busy && sb_msg.size() == 0 && out_val === 1'b0) break;
      for (int i = 0; i < NCH; i++) begin
        if (t < cycles && !pv[i] && $urandom_range(1, 0) == 1) begin pv[i] = 1'b1; pm[i] = W'($urandom); end
        v[i] = pv[i];
        m[i*W +: W] = pm[i];
      end
      r = (t >= cycles) ? 1'b1 : ($urandom_range(3, 0) != 0);
      drive(v, m, r);
      exp_rdy = model_rdy();
      n_tests++; if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy[%0d] got %b want %b", t, in_rdy, exp_rdy); end
      if (out_val === 1'b1 && out_rdy === 1'b1) begin
        n_tests++;
        if (sb_msg.size() == 0) begin
          n_fail++; $display("FAIL rnd_sb_extra[%0d] got %h/%0d want none", t, out_msg, out_chan);
        end else begin
          em = sb_msg.pop_front(); ec = sb_chan.pop_front();
          if (out_msg !== em || out_chan !== IDXW'(ec)) begin
            n_fail++; $display("FAIL rnd_sb_order[%0d] got %h/%0d want %h/%0d", t, out_msg, out_chan, em, ec);
          end
        end
      end
      acc = -1;
      for (int i = 0; i < NCH; i++) if (in_val[i] && in_rdy[i] === 1'b1) acc = i;
      if (acc >= 0) begin sb_msg.push_back(pm[acc]); sb_chan.push_back(acc); end
      tick();
      if (acc >= 0) pv[acc] = 1'b0;
      n_tests++; if (out_val !== m_val || (m_val && (out_msg !== m_msg || out_chan !== IDXW'(m_chan)))) begin
        n_fail++; $display("FAIL rnd_reg[%0d] got %b/%h/%0d want %b/%h/%0d", t, out_val, out_msg, out_chan, m_val, m_msg, m_chan);
      end
    end
    n_tests++; if (sb_msg.size() != 0 || out_val !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain got %0d left/out_val %b want 0/0", sb_msg.size(), out_val);
    end
  endtask

  initial begin
    rst_n = 1'b1; in_val = '0; in_msg = '0; out_rdy = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_wrap_skip();
    test_async_reset();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
